// File: rtl/calculator.sv
// Registered 8-bit arithmetic unit: add, subtract, multiply or divide, signed or unsigned.
// One-cycle latency, one operation accepted every clock.
module calculator (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [7:0]  operand_a,
  input  logic [7:0]  operand_b,
  input  logic        signed_operation,
  output logic [15:0] result,
  output logic        valid,
  output logic        overflow,
  output logic        divide_by_zero
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  logic        neg_a;
  logic        neg_b;
  logic [15:0] ext_a;
  logic [15:0] ext_b;
  logic [15:0] sum;
  logic [15:0] diff;
  logic [15:0] prod;
  logic [7:0]  mag_a;
  logic [7:0]  mag_b;
  logic [7:0]  mag_q;
  logic [7:0]  mag_r;
  logic [7:0]  quo;
  logic [7:0]  rem;
  logic        b_zero;
  logic        fits_signed_sum;
  logic        fits_signed_diff;

  logic [15:0] next_result;
  logic        next_valid;
  logic        next_overflow;
  logic        next_dbz;

  // Full-precision 16-bit arithmetic on sign- or zero-extended operands.
  always_comb begin
    neg_a  = signed_operation & operand_a[7];
    neg_b  = signed_operation & operand_b[7];
    ext_a  = {{8{neg_a}}, operand_a};
    ext_b  = {{8{neg_b}}, operand_b};
    sum    = ext_a + ext_b;
    diff   = ext_a - ext_b;
    prod   = ext_a * ext_b;
    b_zero = (operand_b == 8'h00);

    // Bits 15..7 all equal means the value lies in -128..127.
    fits_signed_sum  = (&sum[15:7])  | ~(|sum[15:7]);
    fits_signed_diff = (&diff[15:7]) | ~(|diff[15:7]);

    // Signed divide runs on magnitudes; -128 has magnitude 0x80, which still fits 8 bits.
    mag_a = neg_a ? 8'(-operand_a) : operand_a;
    mag_b = neg_b ? 8'(-operand_b) : operand_b;
    if (b_zero) begin
      mag_q = 8'h00;
      mag_r = 8'h00;
    end else begin
      mag_q = mag_a / mag_b;
      mag_r = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? 8'(-mag_q) : mag_q;
    rem = neg_a ? 8'(-mag_r) : mag_r;
  end

  always_comb begin
    next_result   = 16'h0000;
    next_valid    = 1'b1;
    next_overflow = 1'b0;
    next_dbz      = 1'b0;
    case (op_e'(mode))
      OP_ADD: begin
        next_result   = sum;
        next_overflow = signed_operation ? ~fits_signed_sum : sum[8];
      end
      OP_SUB: begin
        next_result   = diff;
        next_overflow = signed_operation ? ~fits_signed_diff : (operand_a < operand_b);
      end
      OP_MUL: begin
        next_result = prod;
      end
      OP_DIV: begin
        if (b_zero) begin
          next_valid = 1'b0;
          next_dbz   = 1'b1;
        end else begin
          next_result   = {rem, quo};
          next_overflow = signed_operation && (operand_a == 8'h80) && (operand_b == 8'hFF);
        end
      end
      default: begin
        next_result = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result         <= 16'h0000;
      valid          <= 1'b0;
      overflow       <= 1'b0;
      divide_by_zero <= 1'b0;
    end else begin
      result         <= next_result;
      valid          <= next_valid;
      overflow       <= next_overflow;
      divide_by_zero <= next_dbz;
    end
  end

endmodule

// File: tb/tb_calculator.sv
// Self-checking bench for calculator: directed vector table, async reset sequence,
// and randomized back-to-back traffic against an integer-arithmetic reference model.
module tb_calculator;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        signed_operation;
  logic [15:0] result;
  logic        valid;
  logic        overflow;
  logic        divide_by_zero;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp_result;
    logic        exp_valid;
    logic        exp_overflow;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[$];

  calculator dut (
    .clk              (clk),
    .rst              (rst),
    .mode             (mode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .signed_operation (signed_operation),
    .result           (result),
    .valid            (valid),
    .overflow         (overflow),
    .divide_by_zero   (divide_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain integer arithmetic on the interpreted operand values.
  task automatic model(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic sgn, output logic [15:0] r, output logic v,
                       output logic o, output logic z);
    int va;
    int vb;
    int t;
    int q;
    int rm;
    if (sgn) begin
      va = int'($signed(a));
      vb = int'($signed(b));
    end else begin
      va = int'(a);
      vb = int'(b);
    end
    r = 16'h0000;
    v = 1'b1;
    o = 1'b0;
    z = 1'b0;
    case (m)
      2'b00, 2'b01: begin
        t = (m == 2'b00) ? va + vb : va - vb;
        r = t[15:0];
        if (sgn) o = (t < -128) || (t > 127);
        else     o = (t < 0) || (t > 255);
      end
      2'b10: begin
        t = va * vb;
        r = t[15:0];
      end
      default: begin
        if (vb == 0) begin
          v = 1'b0;
          z = 1'b1;
        end else begin
          q  = va / vb;
          rm = va % vb;
          r  = {rm[7:0], q[7:0]};
          o  = sgn && (va == -128) && (vb == -1);
        end
      end
    endcase
  endtask

  task automatic apply_stimulus(input logic [1:0] m, input logic [7:0] a,
                                input logic [7:0] b, input logic sgn);
    mode             = m;
    operand_a        = a;
    operand_b        = b;
    signed_operation = sgn;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] r, input logic v,
                              input logic o, input logic z);
    tests_run++;
    if (result !== r || valid !== v || overflow !== o || divide_by_zero !== z) begin
      tests_failed++;
      $display("[TB] FAIL %s: got result=%h valid=%b ovf=%b dbz=%b, want result=%h valid=%b ovf=%b dbz=%b",
               name, result, valid, overflow, divide_by_zero, r, v, o, z);
    end
  endtask

  initial begin
    logic [15:0] er;
    logic        ev;
    logic        eo;
    logic        ez;
    logic [1:0]  rm;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;

    vecs.push_back('{2'b00, 8'hFF, 8'h01, 1'b0, 16'h0100, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 8'h7F, 8'h01, 1'b1, 16'h0080, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 8'h03, 8'h05, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 8'hFE, 8'h01, 1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 8'hFF, 8'h02, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'h07, 8'h02, 1'b0, 16'h0103, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'hF9, 8'h02, 1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'h80, 8'hFF, 1'b1, 16'h0080, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2'b11, 8'h12, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{2'b11, 8'h12, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{2'b00, 8'h12, 8'h00, 1'b0, 16'h0012, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 8'h80, 8'hFF, 1'b1, 16'hFF7F, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 8'h80, 8'h01, 1'b1, 16'hFF7F, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2'b00, 8'hFF, 8'hFF, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 8'hFF, 8'h01, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 8'h05, 8'h03, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'hFF, 8'h02, 1'b0, 16'h017F, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'h07, 8'hFE, 1'b1, 16'h01FD, 1'b1, 1'b0, 1'b0});

    rst              = 1'b1;
    mode             = 2'b00;
    operand_a        = 8'h00;
    operand_b        = 8'h00;
    signed_operation = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_initial", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Load a non-zero result, then assert reset between edges.
    apply_stimulus(2'b11, 8'h80, 8'hFF, 1'b1);
    check_output("pre_reset_load", 16'h0080, 1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_output("async_reset_immediate", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_output("reset_held_over_edge", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    apply_stimulus(2'b00, 8'h05, 8'h03, 1'b0);
    check_output("first_after_reset", 16'h0008, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].sgn);
      check_output($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_valid,
                   vecs[i].exp_overflow, vecs[i].exp_dbz);
    end

    // Back-to-back random traffic, new operands every cycle.
    for (int i = 0; i < 400; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        ra = 8'h80;
        rb = 8'hFF;
      end
      rs = 1'($urandom);
      model(rm, ra, rb, rs, er, ev, eo, ez);
      apply_stimulus(rm, ra, rb, rs);
      check_output($sformatf("rand%0d m=%0d a=%h b=%h s=%0d", i, rm, ra, rb, rs),
                   er, ev, eo, ez);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calculator.md
Name: calculator

Overview:
- Registered 8-bit arithmetic unit: add, subtract, multiply or divide two 8-bit operands, unsigned or two's-complement signed.
- Produces a 16-bit result plus valid, overflow and divide-by-zero flags.
- Sits as a leaf datapath block; inputs are sampled every clock and results appear one cycle later.
- No handshake: a new operation may be issued every cycle.

Parameters:
- None. Widths are fixed: operands 8 bits, result 16 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
- operand_a  input  8  first operand (dividend or minuend).
- operand_b  input  8  second operand (divisor or subtrahend).
- signed_operation  input  1  0 = unsigned, 1 = signed two's complement.
- result  output  16  registered result.
- valid  output  1  registered; 1 = result holds a legal completed operation.
- overflow  output  1  registered; 1 = true result does not fit the 8-bit operand format (see rules).
- divide_by_zero  output  1  registered; 1 = divide mode with operand_b = 00.

Behaviour:
Reset and timing
- rst asserted (asynchronously, any time including mid-operation): result = 0000, valid = 0, overflow = 0, divide_by_zero = 0, held while rst = 1.
- After rst deasserts, each rising clk samples mode, operand_a, operand_b and signed_operation.
- The computed result and flags become visible on the outputs after that same edge: latency 1 cycle, throughput 1 per cycle.
- Outputs hold until the next edge. There is no other internal state.

Operand interpretation
- Unsigned: operands zero-extended. Signed: operands sign-extended.
- All arithmetic is computed at full precision and written to the 16-bit result: zero-extended in unsigned mode, sign-extended in signed mode, except where the divide rule below applies.

Add (00)
- result = A + B.
- Unsigned: overflow = carry out of bit 7 (sum > FF).
- Signed: overflow = sum outside -128..127.

Subtract (01)
- result = A - B as a 16-bit two's-complement value.
- Unsigned: overflow = borrow (A < B), e.g. 03-05 gives result FFFE.
- Signed: overflow = difference outside -128..127.

Multiply (10)
- result = full 16-bit product, signed or unsigned.
- overflow = 0 always.

Divide (11)
- result[7:0] = quotient, result[15:8] = remainder.
- Unsigned: plain integer division.
- Signed: quotient truncates toward zero; remainder takes the sign of the dividend; A = Q*B + R.
- Signed 80 / FF (-128 / -1): quotient = 80, remainder = 00, overflow = 1.
- All other divides: overflow = 0.
- A combinational divider is acceptable provided timing is met within one cycle.

Flags
- valid = 1 for every operation except divide by zero.
- Divide with operand_b = 00: result = 0000, valid = 0, overflow = 0, divide_by_zero = 1.
- divide_by_zero = 0 in all other modes, including when operand_b = 00 in a non-divide mode.
- The flags are mutually consistent: valid = 0 if and only if divide_by_zero = 1.

Test Plan:
- Reset asserted mid-stream, asynchronously between edges → all outputs 0 immediately. Release, then apply mode=00, A=05, B=03, signed=0 → after 1 clk: result=0008, valid=1, overflow=0, divide_by_zero=0.
- Add/subtract overflow:
  - mode=00, A=FF, B=01, unsigned → 0100, overflow=1.
  - mode=00, A=7F, B=01, signed → 0080, overflow=1.
  - mode=01, A=03, B=05, unsigned → FFFE, overflow=1.
  - mode=01, A=FE, B=01, signed → FFFD, overflow=0.
- Multiply:
  - A=FF, B=FF unsigned → FE01.
  - A=FF, B=02 signed → FFFE.
  - A=80, B=80 signed → 4000.
  - overflow=0 in all cases.
- Divide:
  - A=07, B=02 unsigned → 0103.
  - A=F9, B=02 signed → FFFD (rem FF, quo FD).
  - A=80, B=FF signed → 0080, overflow=1.
- Divide by zero: mode=11, B=00 (A=12, both signedness settings) → result=0000, valid=0, divide_by_zero=1. Next cycle mode=00, B=00 → valid=1, divide_by_zero=0.
- Back-to-back: change operands every cycle across all four modes → each result appears exactly one cycle after its inputs, with no stale flags carried between cycles.
